// File: rtl/dispatch_router.sv
// In-order dispatch buffer between the front end and the functional-unit issue queues.
// Holds up to Depth instructions, routes the head entry to one of NumFu issue queues,
// snoops the CDB so waiting source operands wake up while stalled, and discards entries
// whose FU index is out of range (err_bad_fu_o pulse).
// Optional feature: define DISPATCH_FLUSH_EN to make a taken-branch broadcast flush the buffer.
module dispatch_router #(
  parameter int unsigned NumFu = 4,
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = 6,
  parameter int unsigned DataW = 32,
  parameter int unsigned OpcW  = 5,
  localparam int unsigned FuW  = $clog2(NumFu),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Front-end side
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FuW-1:0]   in_fu_i,
  input  logic [OpcW-1:0]  in_opcode_i,
  input  logic [TagW-1:0]  in_rd_tag_i,
  input  logic [DataW-1:0] in_rs1_data_i,
  input  logic [DataW-1:0] in_rs2_data_i,
  input  logic [TagW-1:0]  in_rs1_tag_i,
  input  logic [TagW-1:0]  in_rs2_tag_i,
  input  logic             in_rs1_valid_i,
  input  logic             in_rs2_valid_i,
  input  logic [DataW-1:0] in_imm_i,
  // Common data bus
  input  logic             cdb_valid_i,
  input  logic [TagW-1:0]  cdb_tag_i,
  input  logic [DataW-1:0] cdb_data_i,
  input  logic             cdb_branch_i,
  input  logic             cdb_branch_taken_i,
  // Back-end side
  input  logic [NumFu-1:0] issueque_full_i,
  output logic [NumFu-1:0] dispatch_en_o,
  output logic [OpcW-1:0]  dispatch_opcode_o,
  output logic [TagW-1:0]  dispatch_rd_tag_o,
  output logic [DataW-1:0] dispatch_rs1_data_o,
  output logic [TagW-1:0]  dispatch_rs1_tag_o,
  output logic             dispatch_rs1_valid_o,
  output logic [DataW-1:0] dispatch_rs2_data_o,
  output logic [TagW-1:0]  dispatch_rs2_tag_o,
  output logic             dispatch_rs2_valid_o,
  output logic [DataW-1:0] dispatch_imm_o,
  output logic [CntW-1:0]  occupancy_o,
  output logic             err_bad_fu_o
);

  localparam int unsigned PtrW    = $clog2(Depth);
  localparam int unsigned FuCmpW  = FuW + 1;
  // When NumFu fills the select field, no encoding can be out of range.
  localparam bit          FuPow2  = (NumFu == (1 << FuW));

  typedef struct packed {
    logic [FuW-1:0]   fu;
    logic [OpcW-1:0]  opcode;
    logic [TagW-1:0]  rd_tag;
    logic [DataW-1:0] rs1_data;
    logic [TagW-1:0]  rs1_tag;
    logic             rs1_valid;
    logic [DataW-1:0] rs2_data;
    logic [TagW-1:0]  rs2_tag;
    logic             rs2_valid;
    logic [DataW-1:0] imm;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            empty;
  logic            flush;
  logic            push;
  logic            pop;
  logic            bad_pop;
  logic            head_bad;
  logic            head_hit1;
  logic            head_hit2;
  logic            in_hit1;
  logic            in_hit2;
  logic [Depth-1:0] occ;
  entry_t          head;
  entry_t          in_entry;

`ifdef DISPATCH_FLUSH_EN
  // A taken branch squashes everything younger than itself, i.e. the whole buffer.
  assign flush = cdb_valid_i & cdb_branch_i & cdb_branch_taken_i;
`else
  logic unused_branch;
  assign flush         = 1'b0;
  assign unused_branch = cdb_branch_i ^ cdb_branch_taken_i;
`endif

  assign empty       = (count_q == '0);
  // Registered count only: a full buffer never accepts even if the head leaves this cycle.
  assign in_ready_o  = (count_q < CntW'(Depth));
  assign push        = in_valid_i & in_ready_o & ~flush;
  assign occupancy_o = count_q;
  assign head        = mem_q[rd_ptr_q];

  if (FuPow2) begin : g_fu_full_range
    assign head_bad = 1'b0;
  end else begin : g_fu_partial_range
    assign head_bad = ({1'b0, head.fu} >= FuCmpW'(NumFu));
  end

  // Head-of-buffer routing: only the head may leave, and only if its queue has room.
  always_comb begin
    dispatch_en_o = '0;
    for (int i = 0; i < NumFu; i++) begin
      if (!empty && !flush && (head.fu == FuW'(i)) && !issueque_full_i[i]) begin
        dispatch_en_o[i] = 1'b1;
      end
    end
  end

  assign bad_pop      = ~empty & ~flush & head_bad;
  assign err_bad_fu_o = bad_pop;
  assign pop          = (|dispatch_en_o) | bad_pop;

  // Same-cycle CDB bypass on the head so a broadcast is never lost at dispatch.
  assign head_hit1 = ~empty & cdb_valid_i & ~head.rs1_valid & (head.rs1_tag == cdb_tag_i);
  assign head_hit2 = ~empty & cdb_valid_i & ~head.rs2_valid & (head.rs2_tag == cdb_tag_i);

  assign dispatch_opcode_o    = head.opcode;
  assign dispatch_rd_tag_o    = head.rd_tag;
  assign dispatch_rs1_tag_o   = head.rs1_tag;
  assign dispatch_rs2_tag_o   = head.rs2_tag;
  assign dispatch_imm_o       = head.imm;
  assign dispatch_rs1_valid_o = head.rs1_valid | head_hit1;
  assign dispatch_rs2_valid_o = head.rs2_valid | head_hit2;
  assign dispatch_rs1_data_o  = head_hit1 ? cdb_data_i : head.rs1_data;
  assign dispatch_rs2_data_o  = head_hit2 ? cdb_data_i : head.rs2_data;

  // Incoming instruction captures a broadcast that lands in its push cycle.
  assign in_hit1 = cdb_valid_i & ~in_rs1_valid_i & (in_rs1_tag_i == cdb_tag_i);
  assign in_hit2 = cdb_valid_i & ~in_rs2_valid_i & (in_rs2_tag_i == cdb_tag_i);

  // Assemble the entry written on push.
  always_comb begin
    in_entry.fu        = in_fu_i;
    in_entry.opcode    = in_opcode_i;
    in_entry.rd_tag    = in_rd_tag_i;
    in_entry.rs1_tag   = in_rs1_tag_i;
    in_entry.rs1_valid = in_rs1_valid_i | in_hit1;
    in_entry.rs1_data  = in_hit1 ? cdb_data_i : in_rs1_data_i;
    in_entry.rs2_tag   = in_rs2_tag_i;
    in_entry.rs2_valid = in_rs2_valid_i | in_hit2;
    in_entry.rs2_data  = in_hit2 ? cdb_data_i : in_rs2_data_i;
    in_entry.imm       = in_imm_i;
  end

  // Mark which slots currently hold live entries (distance from rd_ptr below count).
  always_comb begin
    occ = '0;
    for (int i = 0; i < Depth; i++) begin
      occ[i] = ({1'b0, PtrW'(PtrW'(i) - rd_ptr_q)} < count_q);
    end
  end

  // Entry storage next state: CDB wakeup of live entries, then the push write.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if (occ[i] && cdb_valid_i) begin
        // Already-valid sources are left untouched even on a tag match.
        if (!mem_q[i].rs1_valid && (mem_q[i].rs1_tag == cdb_tag_i)) begin
          mem_d[i].rs1_valid = 1'b1;
          mem_d[i].rs1_data  = cdb_data_i;
        end
        if (!mem_q[i].rs2_valid && (mem_q[i].rs2_tag == cdb_tag_i)) begin
          mem_d[i].rs2_valid = 1'b1;
          mem_d[i].rs2_data  = cdb_data_i;
        end
      end
    end
    // wr_ptr never points at a live slot when push is allowed.
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
    end
  end

  // Pointer and occupancy next state; a flush wins over everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: a 4-FU instance for the main scenarios and a
// 3-FU instance for the out-of-range FU path. Expected dispatch order comes from a queue
// filled as instructions are accepted.
module tb_dispatch_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        sel3;
  logic [1:0]  in_fu;
  logic [4:0]  in_opcode;
  logic [5:0]  in_rd_tag;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [5:0]  in_rs1_tag, in_rs2_tag;
  logic        in_rs1_valid, in_rs2_valid;
  logic        cdb_valid, cdb_branch, cdb_branch_taken;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  issueque_full;

  logic        in_valid_a, in_valid_b;
  assign in_valid_a = in_valid & ~sel3;
  assign in_valid_b = in_valid & sel3;

  // Instance A outputs (NumFu = 4)
  logic        in_ready_a, err_a;
  logic [3:0]  en_a;
  logic [4:0]  opc_a;
  logic [5:0]  rd_tag_a, rs1_tag_a, rs2_tag_a;
  logic [31:0] rs1_data_a, rs2_data_a, imm_a;
  logic        rs1_valid_a, rs2_valid_a;
  logic [2:0]  occ_a;

  // Instance B outputs (NumFu = 3)
  logic        in_ready_b, err_b;
  logic [2:0]  en_b;
  logic [4:0]  opc_b;
  logic [5:0]  rd_tag_b, rs1_tag_b, rs2_tag_b;
  logic [31:0] rs1_data_b, rs2_data_b, imm_b;
  logic        rs1_valid_b, rs2_valid_b;
  logic [2:0]  occ_b;

  dispatch_router u_dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .in_valid_i           (in_valid_a),
    .in_ready_o           (in_ready_a),
    .in_fu_i              (in_fu),
    .in_opcode_i          (in_opcode),
    .in_rd_tag_i          (in_rd_tag),
    .in_rs1_data_i        (in_rs1_data),
    .in_rs2_data_i        (in_rs2_data),
    .in_rs1_tag_i         (in_rs1_tag),
    .in_rs2_tag_i         (in_rs2_tag),
    .in_rs1_valid_i       (in_rs1_valid),
    .in_rs2_valid_i       (in_rs2_valid),
    .in_imm_i             (in_imm),
    .cdb_valid_i          (cdb_valid),
    .cdb_tag_i            (cdb_tag),
    .cdb_data_i           (cdb_data),
    .cdb_branch_i         (cdb_branch),
    .cdb_branch_taken_i   (cdb_branch_taken),
    .issueque_full_i      (issueque_full),
    .dispatch_en_o        (en_a),
    .dispatch_opcode_o    (opc_a),
    .dispatch_rd_tag_o    (rd_tag_a),
    .dispatch_rs1_data_o  (rs1_data_a),
    .dispatch_rs1_tag_o   (rs1_tag_a),
    .dispatch_rs1_valid_o (rs1_valid_a),
    .dispatch_rs2_data_o  (rs2_data_a),
    .dispatch_rs2_tag_o   (rs2_tag_a),
    .dispatch_rs2_valid_o (rs2_valid_a),
    .dispatch_imm_o       (imm_a),
    .occupancy_o          (occ_a),
    .err_bad_fu_o         (err_a)
  );

  dispatch_router #(.NumFu(3)) u_dut3 (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .in_valid_i           (in_valid_b),
    .in_ready_o           (in_ready_b),
    .in_fu_i              (in_fu),
    .in_opcode_i          (in_opcode),
    .in_rd_tag_i          (in_rd_tag),
    .in_rs1_data_i        (in_rs1_data),
    .in_rs2_data_i        (in_rs2_data),
    .in_rs1_tag_i         (in_rs1_tag),
    .in_rs2_tag_i         (in_rs2_tag),
    .in_rs1_valid_i       (in_rs1_valid),
    .in_rs2_valid_i       (in_rs2_valid),
    .in_imm_i             (in_imm),
    .cdb_valid_i          (cdb_valid),
    .cdb_tag_i            (cdb_tag),
    .cdb_data_i           (cdb_data),
    .cdb_branch_i         (cdb_branch),
    .cdb_branch_taken_i   (cdb_branch_taken),
    .issueque_full_i      (issueque_full[2:0]),
    .dispatch_en_o        (en_b),
    .dispatch_opcode_o    (opc_b),
    .dispatch_rd_tag_o    (rd_tag_b),
    .dispatch_rs1_data_o  (rs1_data_b),
    .dispatch_rs1_tag_o   (rs1_tag_b),
    .dispatch_rs1_valid_o (rs1_valid_b),
    .dispatch_rs2_data_o  (rs2_data_b),
    .dispatch_rs2_tag_o   (rs2_tag_b),
    .dispatch_rs2_valid_o (rs2_valid_b),
    .dispatch_imm_o       (imm_b),
    .occupancy_o          (occ_b),
    .err_bad_fu_o         (err_b)
  );

  typedef struct packed {
    logic [1:0] fu;
    logic [5:0] tag;
  } sb_t;

  sb_t sb_q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] fu, input logic [5:0] tag,
                            input logic [5:0] t1, input logic v1, input logic [31:0] d1,
                            input logic [5:0] t2, input logic v2, input logic [31:0] d2);
    in_fu        = fu;
    in_rd_tag    = tag;
    in_opcode    = tag[4:0];
    in_imm       = {26'd0, tag};
    in_rs1_tag   = t1;
    in_rs1_valid = v1;
    in_rs1_data  = d1;
    in_rs2_tag   = t2;
    in_rs2_valid = v2;
    in_rs2_data  = d2;
  endtask

  // Offer one instruction for a cycle; record it as expected output if it was accepted.
  task automatic push_one(input logic [1:0] fu, input logic [5:0] tag,
                          input logic [5:0] t1, input logic v1, input logic [31:0] d1,
                          input logic [5:0] t2, input logic v2, input logic [31:0] d2,
                          output logic acc);
    set_fields(fu, tag, t1, v1, d1, t2, v2, d2);
    in_valid = 1'b1;
    #1;
    acc = sel3 ? in_ready_b : in_ready_a;
    if (acc) sb_q.push_back('{fu: fu, tag: tag});
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic acc;
    total++; if (occ_a !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occ_a); else passed++;
    total++; if (in_ready_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready_a);
    else passed++;
    total++; if (en_a !== 4'b0) $display("FAIL reset_en: got %b want 0000", en_a); else passed++;
    total++; if (err_a !== 1'b0 || err_b !== 1'b0) $display("FAIL reset_err: got %b%b want 00",
      err_a, err_b); else passed++;
    total++; if (rd_tag_a !== 6'd0 || rs1_data_a !== 32'd0 || rs1_valid_a !== 1'b0)
      $display("FAIL reset_payload: tag=%0d d=%h v=%b want 0", rd_tag_a, rs1_data_a, rs1_valid_a);
    else passed++;
    total++; if (occ_b !== 3'd0) $display("FAIL reset_occ3: got %0d want 0", occ_b); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    // Reset in the middle of operation with three entries held.
    issueque_full = 4'b0100;
    for (int k = 0; k < 3; k++) push_one(2'd2, 6'(k + 1), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    #1;
    total++; if (occ_a !== 3'd3) $display("FAIL midrst_occ_before: got %0d want 3", occ_a);
    else passed++;
    issueque_full = 4'b0000;
    #1;
    total++; if (en_a !== 4'b0100) $display("FAIL midrst_en_before: got %b want 0100", en_a);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (occ_a !== 3'd0 || en_a !== 4'b0 || in_ready_a !== 1'b1)
      $display("FAIL midrst_async: occ=%0d en=%b rdy=%b want 0 0000 1", occ_a, en_a, in_ready_a);
    else passed++;
    cyc();
    rst_n = 1'b1;
    sb_q.delete();
    cyc();
  endtask

  task automatic test_fill_stall();
    logic acc;
    sb_t  e;
    issueque_full = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      push_one(2'd2, 6'(k + 1), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
      total++; if (acc !== (k < 4)) $display("FAIL fill_accept%0d: got %b want %b", k, acc, k < 4);
      else passed++;
    end
    #1;
    total++; if (in_ready_a !== 1'b0 || en_a !== 4'b0 || occ_a !== 3'd4)
      $display("FAIL fill_full: rdy=%b en=%b occ=%0d want 0 0000 4", in_ready_a, en_a, occ_a);
    else passed++;
    cyc();
    issueque_full = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = sb_q.pop_front();
      total++;
      if (en_a !== (4'b0001 << e.fu) || rd_tag_a !== e.tag || opc_a !== e.tag[4:0])
        $display("FAIL fill_drain%0d: en=%b tag=%0d want en=%b tag=%0d", k, en_a, rd_tag_a,
                 4'b0001 << e.fu, e.tag);
      else passed++;
      cyc();
    end
    #1;
    total++; if (occ_a !== 3'd0 || en_a !== 4'b0) $display("FAIL fill_empty: occ=%0d en=%b want 0",
      occ_a, en_a); else passed++;
    cyc();
  endtask

  task automatic test_hol_block();
    logic acc;
    sb_t  e;
    issueque_full = 4'b0010;
    push_one(2'd1, 6'd10, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    push_one(2'd3, 6'd11, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (en_a !== 4'b0 || occ_a !== 3'd2)
        $display("FAIL hol_blocked%0d: en=%b occ=%0d want 0000 2", k, en_a, occ_a); else passed++;
      cyc();
    end
    issueque_full = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      e = sb_q.pop_front();
      total++;
      if (en_a !== (4'b0001 << e.fu) || rd_tag_a !== e.tag)
        $display("FAIL hol_drain%0d: en=%b tag=%0d want en=%b tag=%0d", k, en_a, rd_tag_a,
                 4'b0001 << e.fu, e.tag);
      else passed++;
      cyc();
    end
  endtask

  task automatic test_wakeup();
    logic acc;
    sb_t  e;
    issueque_full = 4'b0001;
    push_one(2'd0, 6'd20, 6'd9, 1'b0, 32'h1111_1111, 6'd9, 1'b1, 32'h2222_2222, acc);
    #1;
    total++; if (rs1_valid_a !== 1'b0) $display("FAIL wake_pending: got %b want 0", rs1_valid_a);
    else passed++;
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEAD_BEEF;
    #1;
    total++; if (rs1_valid_a !== 1'b1 || rs1_data_a !== 32'hDEAD_BEEF)
      $display("FAIL wake_bypass_stalled: v=%b d=%h want 1 deadbeef", rs1_valid_a, rs1_data_a);
    else passed++;
    cyc();
    cdb_valid = 1'b0;
    #1;
    total++; if (rs1_valid_a !== 1'b1 || rs1_data_a !== 32'hDEAD_BEEF || rs2_data_a !== 32'h2222_2222)
      $display("FAIL wake_captured: v=%b d1=%h d2=%h want 1 deadbeef 22222222", rs1_valid_a,
               rs1_data_a, rs2_data_a);
    else passed++;
    issueque_full = 4'b0000;
    #1;
    e = sb_q.pop_front();
    total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag)
      $display("FAIL wake_disp1: en=%b tag=%0d want 0001 %0d", en_a, rd_tag_a, e.tag); else passed++;
    cyc();
    // Dispatch in the broadcast cycle itself.
    issueque_full = 4'b0001;
    push_one(2'd0, 6'd21, 6'd12, 1'b0, 32'd0, 6'd13, 1'b0, 32'd0, acc);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hCAFE_F00D;
    issueque_full = 4'b0000;
    #1;
    e = sb_q.pop_front();
    total++;
    if (en_a !== 4'b0001 || rd_tag_a !== e.tag || rs1_valid_a !== 1'b1 ||
        rs1_data_a !== 32'hCAFE_F00D || rs2_valid_a !== 1'b0)
      $display("FAIL wake_same_cycle: en=%b tag=%0d v1=%b d1=%h v2=%b want 0001 %0d 1 cafef00d 0",
               en_a, rd_tag_a, rs1_valid_a, rs1_data_a, rs2_valid_a, e.tag);
    else passed++;
    cyc();
    cdb_valid = 1'b0;
    // Broadcast landing in the push cycle is captured into the new entry.
    issueque_full = 4'b0001;
    cdb_valid = 1'b1; cdb_tag = 6'd15; cdb_data = 32'h5555_5555;
    push_one(2'd0, 6'd22, 6'd15, 1'b0, 32'd0, 6'd15, 1'b1, 32'h7777_7777, acc);
    cdb_valid = 1'b0;
    #1;
    total++; if (rs1_valid_a !== 1'b1 || rs1_data_a !== 32'h5555_5555 || rs2_data_a !== 32'h7777_7777)
      $display("FAIL wake_on_push: v=%b d1=%h d2=%h want 1 55555555 77777777", rs1_valid_a,
               rs1_data_a, rs2_data_a);
    else passed++;
    issueque_full = 4'b0000;
    #1;
    e = sb_q.pop_front();
    total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag)
      $display("FAIL wake_disp3: en=%b tag=%0d want 0001 %0d", en_a, rd_tag_a, e.tag); else passed++;
    cyc();
  endtask

  task automatic test_latency();
    sb_t e;
    issueque_full = 4'b0000;
    set_fields(2'd3, 6'd50, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    in_valid = 1'b1;
    #1;
    total++; if (en_a !== 4'b0 || in_ready_a !== 1'b1)
      $display("FAIL lat_push_cycle: en=%b rdy=%b want 0000 1", en_a, in_ready_a); else passed++;
    sb_q.push_back('{fu: 2'd3, tag: 6'd50});
    cyc();
    in_valid = 1'b0;
    #1;
    e = sb_q.pop_front();
    total++; if (en_a !== (4'b0001 << e.fu) || rd_tag_a !== e.tag)
      $display("FAIL lat_next_cycle: en=%b tag=%0d want 1000 %0d", en_a, rd_tag_a, e.tag);
    else passed++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic acc;
    sb_t  e;
    issueque_full = 4'b0001;
    push_one(2'd0, 6'd30, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    push_one(2'd0, 6'd31, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    issueque_full = 4'b0000;
    // Four push+pop cycles at count 2 guarantee both pointers wrap.
    for (int k = 0; k < 4; k++) begin
      set_fields(2'd0, 6'(32 + k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
      in_valid = 1'b1;
      #1;
      if (in_ready_a) sb_q.push_back('{fu: 2'd0, tag: 6'(32 + k)});
      e = sb_q.pop_front();
      total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag || in_ready_a !== 1'b1)
        $display("FAIL b2b_disp%0d: en=%b tag=%0d rdy=%b want 0001 %0d 1", k, en_a, rd_tag_a,
                 in_ready_a, e.tag);
      else passed++;
      cyc();
      in_valid = 1'b0;
      #1;
      total++; if (occ_a !== 3'd2) $display("FAIL b2b_occ%0d: got %0d want 2", k, occ_a);
      else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag)
        $display("FAIL b2b_drain%0d: en=%b tag=%0d want 0001 %0d", k, en_a, rd_tag_a, e.tag);
      else passed++;
      cyc();
      #1;
    end
    total++; if (occ_a !== 3'd0) $display("FAIL b2b_empty: got %0d want 0", occ_a); else passed++;
    cyc();
  endtask

  task automatic test_bad_fu();
    logic       acc;
    sb_t        e;
    logic [2:0] exp_en;
    sel3 = 1'b1;
    issueque_full = 4'b0111;
    push_one(2'd1, 6'd40, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    push_one(2'd3, 6'd41, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    push_one(2'd2, 6'd42, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    #1;
    total++; if (occ_b !== 3'd3 || err_b !== 1'b0)
      $display("FAIL badfu_held: occ=%0d err=%b want 3 0", occ_b, err_b); else passed++;
    issueque_full = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = sb_q.pop_front();
      exp_en = (e.fu < 2'd3) ? (3'b001 << e.fu) : 3'b000;
      total++; if (en_b !== exp_en || err_b !== (e.fu == 2'd3) || rd_tag_b !== e.tag)
        $display("FAIL badfu_step%0d: en=%b err=%b tag=%0d want %b %b %0d", k, en_b, err_b,
                 rd_tag_b, exp_en, e.fu == 2'd3, e.tag);
      else passed++;
      cyc();
    end
    #1;
    total++; if (occ_b !== 3'd0 || err_b !== 1'b0)
      $display("FAIL badfu_done: occ=%0d err=%b want 0 0", occ_b, err_b); else passed++;
    sel3 = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    logic acc;
    sb_t  e;
    issueque_full = 4'b0001;
    for (int k = 0; k < 3; k++) push_one(2'd0, 6'(60 + k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, acc);
    issueque_full = 4'b0000;
    cdb_valid = 1'b1; cdb_tag = 6'd63; cdb_data = 32'd0;
    cdb_branch = 1'b1; cdb_branch_taken = 1'b1;
    set_fields(2'd0, 6'd59, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    in_valid = 1'b1;
    #1;
`ifdef DISPATCH_FLUSH_EN
    total++; if (en_a !== 4'b0 || in_ready_a !== 1'b1)
      $display("FAIL flush_cycle: en=%b rdy=%b want 0000 1", en_a, in_ready_a); else passed++;
    cyc();
    in_valid = 1'b0; cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    #1;
    total++; if (occ_a !== 3'd0 || in_ready_a !== 1'b1 || en_a !== 4'b0)
      $display("FAIL flush_after: occ=%0d rdy=%b en=%b want 0 1 0000", occ_a, in_ready_a, en_a);
    else passed++;
    sb_q.delete();
    cyc();
`else
    if (in_ready_a) sb_q.push_back('{fu: 2'd0, tag: 6'd59});
    e = sb_q.pop_front();
    total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag)
      $display("FAIL noflush_cycle: en=%b tag=%0d want 0001 %0d", en_a, rd_tag_a, e.tag);
    else passed++;
    cyc();
    in_valid = 1'b0; cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    #1;
    total++; if (occ_a !== 3'd3) $display("FAIL noflush_occ: got %0d want 3", occ_a); else passed++;
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      total++; if (en_a !== 4'b0001 || rd_tag_a !== e.tag)
        $display("FAIL noflush_drain%0d: en=%b tag=%0d want 0001 %0d", k, en_a, rd_tag_a, e.tag);
      else passed++;
      cyc();
      #1;
    end
    cyc();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    sel3 = 1'b0;
    set_fields(2'd0, 6'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
    cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_data = 32'd0;
    cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    issueque_full = 4'b0000;
    #2;
    test_reset();
    test_fill_stall();
    test_hol_block();
    test_wakeup();
    test_latency();
    test_back_to_back();
    test_bad_fu();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dispatch_router.md
Name: dispatch_router

Overview:
- Parametrised dispatch buffer between the front end and the back end.
- Replaces the fixed four-lane point-to-point dispatch hookup with an in-order FIFO of DEPTH entries that routes each instruction to one of NUM_FU issue queues.
- Snoops the CDB so operands waiting in the buffer wake up while the instruction is stalled.
- Honours each issue queue's full flag independently.

Parameters:
- NUM_FU, 4, number of functional-unit issue queues (>=2).
- DEPTH, 4, buffer entries (power of 2, >=2).
- TAG_W, 6, physical tag width.
- DATA_W, 32, operand/immediate width.
- OPC_W, 5, opcode width.
- FU_W, $clog2(NUM_FU), FU select width (localparam).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  front end offers an instruction.
- in_ready  out  1  buffer can accept.
- in_fu  in  FU_W  target issue-queue index.
- in_opcode  in  OPC_W  opcode.
- in_rd_tag  in  TAG_W  destination tag.
- in_rs1_data / in_rs2_data  in  DATA_W  source values.
- in_rs1_tag / in_rs2_tag  in  TAG_W  source tags.
- in_rs1_valid / in_rs2_valid  in  1  source value present.
- in_imm  in  DATA_W  immediate.
- CDB_valid  in  1  broadcast valid.
- CDB_tag  in  TAG_W  broadcast tag.
- CDB_data  in  DATA_W  broadcast value.
- CDB_branch  in  1  broadcast is a branch.
- CDB_branch_taken  in  1  branch outcome.
- issueque_full  in  NUM_FU  per-queue full flag.
- dispatch_en  out  NUM_FU  one-hot dispatch strobe.
- dispatch_opcode, dispatch_rd_tag, dispatch_rs1_data/tag/valid, dispatch_rs2_data/tag/valid, dispatch_imm  out  as inputs  head-entry payload.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- err_bad_fu  out  1  one-cycle pulse when an entry with in_fu >= NUM_FU is discarded.

Behaviour:
- Reset (reset=0, async):
  - count=0, rd/wr pointers=0, all entry fields=0.
  - dispatch_en=0, err_bad_fu=0, in_ready=1, payload outputs 0.
- Push:
  - in_ready = (count < DEPTH). It depends only on registered count, never on same-cycle pop, so there is no full-buffer pass-through.
  - push = in_valid & in_ready. The entry is written at wr_ptr and wr_ptr wraps mod DEPTH.
- Head:
  - Payload outputs are combinational from the entry at rd_ptr.
  - When empty, dispatch_en=0 and the payload is don't-care (holds the last entry).
- Dispatch:
  - dispatch_en[i] = !empty & head.fu==i & !issueque_full[i].
  - pop = |dispatch_en.
  - Latency: 1 cycle minimum from push to dispatch, since an empty-buffer push appears at the head next cycle.
  - Strict in-order. A blocked head stalls all younger entries even if their queues are free.
- Bad FU: if head.fu >= NUM_FU, the entry is popped with dispatch_en=0 and err_bad_fu pulses the same cycle.
- Counting: simultaneous push and pop leaves count unchanged and both pointers advance.
- CDB wakeup:
  - Each cycle, for every occupied entry and each source: if !valid & CDB_valid & tag==CDB_tag, then data<=CDB_data and valid<=1 at the next edge.
  - The incoming instruction is checked against the same-cycle CDB, and captured data is written on push.
  - Head bypass: dispatch_rsN_valid/data are OR/muxed with a same-cycle CDB match. An instruction dispatched in the broadcast cycle never misses it.
- Already-valid sources are never overwritten.
- A tag match on a source with valid=1 is ignored.

Optional Feature:
- Macro: DISPATCH_FLUSH_EN.
- Defined:
  - When CDB_valid & CDB_branch & CDB_branch_taken, dispatch_en is forced 0 that cycle and any push that cycle is dropped.
  - At the next edge, count and pointers clear to 0; in_ready is 1 the following cycle.
- Undefined: CDB_branch and CDB_branch_taken are ignored (ports remain present).

Test Plan:
- Reset mid-operation: 3 entries held, reset low -> occupancy=0, dispatch_en=0 immediately (async); in_ready=1.
- Fill/stall: DEPTH=4, push 5 instructions with fu=2, issueque_full=4'b0100 -> in_ready=0 after 4 pushes, dispatch_en=0. Deassert full -> dispatch_en=4'b0100 one per cycle, in program order by rd_tag 1..4.
- Head-of-line blocking: entries fu=1 then fu=3, issueque_full[1]=1 -> no dispatch_en[3] until full[1] drops.
- Wakeup: entry rs1_tag=6'd9, valid=0, stalled. CDB tag 9, data 32'hDEAD_BEEF -> next cycle dispatch_rs1_valid=1, data DEADBEEF. Repeat with dispatch in the broadcast cycle -> bypassed valid=1 same cycle.
- Simultaneous push+pop at count=2 -> count stays 2; pointer wrap across index 3->0 preserves order.
- Bad FU and flush: NUM_FU=3, push fu=3 -> err_bad_fu=1 one cycle, no dispatch_en. With DISPATCH_FLUSH_EN, CDB taken branch at count=3 -> occupancy=0 next cycle, no dispatch that cycle.
